// File: rtl/touch_pkg.sv
// Shared types and screen geometry for the touch conditioning path.
package touch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSING  = 2'd1,
    TOUCHED   = 2'd2,
    RELEASING = 2'd3
  } touch_state_t;

  localparam int TFT_WIDTH  = 480;
  localparam int TFT_HEIGHT = 272;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;
  localparam int RAW_W      = 9;
  localparam int ACC_W      = 13;

endpackage

// File: rtl/touch_axis_scale.sv
// Combinational per-axis conversion: subtract offset, shift down, clamp to MAX.
module touch_axis_scale #(
  parameter int IN_W   = 13,
  parameter int OUT_W  = 10,
  parameter int OFFSET = 150,
  parameter int SHIFT  = 3,
  parameter int MAX    = 479
) (
  input  logic [IN_W-1:0]  avg,
  output logic [OUT_W-1:0] scaled
);

  localparam logic [IN_W:0]   OFF_EXT = (IN_W + 1)'(OFFSET);
  localparam logic [IN_W-1:0] MAX_V   = IN_W'(MAX);

  logic [IN_W:0]   diff_ext;
  logic [IN_W-1:0] shifted;

  // The extra top bit of the difference is the borrow, so avg < OFFSET never wraps.
  always_comb begin
    diff_ext = {1'b0, avg} - OFF_EXT;
    shifted  = diff_ext[IN_W-1:0] >> SHIFT;
    if (diff_ext[IN_W]) begin
      scaled = '0;
    end else if (shifted > MAX_V) begin
      scaled = OUT_W'(MAX);
    end else begin
      scaled = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/touch_conditioner.sv
// Samples raw touch data, debounces press/release, block-averages and scales
// the position, and publishes it to the display only on frame boundaries.
module touch_conditioner
  import touch_pkg::*;
#(
  parameter int SAMPLE_DIV    = 100000,
  parameter int Z_THRESH      = 256,
  parameter int PRESS_COUNT   = 3,
  parameter int RELEASE_COUNT = 3,
  parameter int AVG_LOG2      = 2,
  parameter int X_OFFSET      = 150,
  parameter int Y_OFFSET      = 300,
  parameter int X_SHIFT       = 3,
  parameter int Y_SHIFT       = 3
) (
  input  logic             cclk,
  input  logic             reset,
  input  logic [RAW_W-1:0] touch_x,
  input  logic [RAW_W-1:0] touch_y,
  input  logic [RAW_W-1:0] touch_z,
  input  logic             new_frame,
  output logic [X_W-1:0]   locked_x,
  output logic [Y_W-1:0]   locked_y,
  output logic             touch_valid,
  output logic             press_pulse,
  output logic             release_pulse
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BLOCK = 1 << AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;

  logic [CNT_W-1:0] div_reg;
  logic             tick;
  logic [RAW_W-1:0] samp_x_reg, samp_y_reg;
  logic             pressed_reg, sample_reg;

  touch_state_t state_reg, state_next;
  logic [7:0]   dcnt_reg, dcnt_next;
  logic [ACC_W-1:0] acc_x_reg, acc_x_next, acc_y_reg, acc_y_next;
  logic [N_W-1:0]   n_reg, n_next;
  logic [X_W-1:0]   pend_x_reg, pend_x_next, locked_x_reg, locked_x_next;
  logic [Y_W-1:0]   pend_y_reg, pend_y_next, locked_y_reg, locked_y_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             press_reg, press_next, release_reg, release_next;
  logic             clear_acc, acc_en;

  logic [ACC_W-1:0] sum_x, sum_y, avg_x, avg_y;
  logic [X_W-1:0]   scaled_x;
  logic [Y_W-1:0]   scaled_y;

  assign tick = (div_reg == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge cclk) begin
    if (reset) begin
      div_reg     <= '0;
      samp_x_reg  <= '0;
      samp_y_reg  <= '0;
      pressed_reg <= 1'b0;
      sample_reg  <= 1'b0;
    end else begin
      div_reg    <= tick ? '0 : div_reg + 1'b1;
      sample_reg <= tick;
      if (tick) begin
        samp_x_reg  <= touch_x;
        samp_y_reg  <= touch_y;
        pressed_reg <= (touch_z >= RAW_W'(Z_THRESH));
      end
    end
  end

  // Running sum including the current sample, so a completing block scales in one pass.
  assign sum_x = acc_x_reg + ACC_W'(samp_x_reg);
  assign sum_y = acc_y_reg + ACC_W'(samp_y_reg);
  assign avg_x = sum_x >> AVG_LOG2;
  assign avg_y = sum_y >> AVG_LOG2;

  touch_axis_scale #(
    .IN_W(ACC_W), .OUT_W(X_W), .OFFSET(X_OFFSET), .SHIFT(X_SHIFT), .MAX(TFT_WIDTH - 1)
  ) u_scale_x (
    .avg(avg_x), .scaled(scaled_x)
  );

  touch_axis_scale #(
    .IN_W(ACC_W), .OUT_W(Y_W), .OFFSET(Y_OFFSET), .SHIFT(Y_SHIFT), .MAX(TFT_HEIGHT - 1)
  ) u_scale_y (
    .avg(avg_y), .scaled(scaled_y)
  );

  assign touch_valid = (state_reg == TOUCHED) || (state_reg == RELEASING);

  always_comb begin
    state_next      = state_reg;
    dcnt_next       = dcnt_reg;
    acc_x_next      = acc_x_reg;
    acc_y_next      = acc_y_reg;
    n_next          = n_reg;
    pend_x_next     = pend_x_reg;
    pend_y_next     = pend_y_reg;
    pend_valid_next = pend_valid_reg;
    locked_x_next   = locked_x_reg;
    locked_y_next   = locked_y_reg;
    press_next      = 1'b0;
    release_next    = 1'b0;
    clear_acc       = 1'b0;
    acc_en          = 1'b0;

    // Commit uses pre-edge pending data; a block finishing this cycle overrides pend_valid below.
    if (new_frame && pend_valid_reg && touch_valid) begin
      locked_x_next   = pend_x_reg;
      locked_y_next   = pend_y_reg;
      pend_valid_next = 1'b0;
    end

    if (sample_reg) begin
      case (state_reg)
        IDLE: begin
          if (pressed_reg) begin
            clear_acc = 1'b1;
            if (PRESS_COUNT <= 1) begin
              state_next = TOUCHED;
              press_next = 1'b1;
              dcnt_next  = '0;
            end else begin
              state_next = PRESSING;
              dcnt_next  = 8'd1;
            end
          end
        end
        PRESSING: begin
          if (pressed_reg) begin
            if (dcnt_reg + 8'd1 >= 8'(PRESS_COUNT)) begin
              state_next = TOUCHED;
              press_next = 1'b1;
              dcnt_next  = '0;
            end else begin
              dcnt_next = dcnt_reg + 8'd1;
            end
          end else begin
            state_next = IDLE;
            dcnt_next  = '0;
            clear_acc  = 1'b1;
          end
        end
        TOUCHED: begin
          if (pressed_reg) begin
            acc_en = 1'b1;
          end else if (RELEASE_COUNT <= 1) begin
            state_next   = IDLE;
            release_next = 1'b1;
            dcnt_next    = '0;
            clear_acc    = 1'b1;
          end else begin
            state_next = RELEASING;
            dcnt_next  = 8'd1;
          end
        end
        RELEASING: begin
          if (pressed_reg) begin
            state_next = TOUCHED;
            dcnt_next  = '0;
            acc_en     = 1'b1;
          end else if (dcnt_reg + 8'd1 >= 8'(RELEASE_COUNT)) begin
            state_next   = IDLE;
            release_next = 1'b1;
            dcnt_next    = '0;
            clear_acc    = 1'b1;
          end else begin
            dcnt_next = dcnt_reg + 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (clear_acc) begin
      acc_x_next      = '0;
      acc_y_next      = '0;
      n_next          = '0;
      pend_valid_next = 1'b0;
    end else if (acc_en) begin
      if (n_reg == N_W'(BLOCK - 1)) begin
        pend_x_next     = scaled_x;
        pend_y_next     = scaled_y;
        pend_valid_next = 1'b1;
        acc_x_next      = '0;
        acc_y_next      = '0;
        n_next          = '0;
      end else begin
        acc_x_next = sum_x;
        acc_y_next = sum_y;
        n_next     = n_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      state_reg      <= IDLE;
      dcnt_reg       <= '0;
      acc_x_reg      <= '0;
      acc_y_reg      <= '0;
      n_reg          <= '0;
      pend_x_reg     <= '0;
      pend_y_reg     <= '0;
      pend_valid_reg <= 1'b0;
      locked_x_reg   <= '0;
      locked_y_reg   <= '0;
      press_reg      <= 1'b0;
      release_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dcnt_reg       <= dcnt_next;
      acc_x_reg      <= acc_x_next;
      acc_y_reg      <= acc_y_next;
      n_reg          <= n_next;
      pend_x_reg     <= pend_x_next;
      pend_y_reg     <= pend_y_next;
      pend_valid_reg <= pend_valid_next;
      locked_x_reg   <= locked_x_next;
      locked_y_reg   <= locked_y_next;
      press_reg      <= press_next;
      release_reg    <= release_next;
    end
  end

  assign locked_x      = locked_x_reg;
  assign locked_y      = locked_y_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

endmodule
